p2p_mult_ctrl: RTL and testbench

Sequencer for the point-to-point (element-wise) matrix multiplier. It accepts a start pulse, serially loads N_ELEM operands of matrix A and then N_ELEM of matrix B over one byte stream, and time-shares a single multiplier across all element pairs. Results stream out in index order under a valid/ready handshake, and done pulses at the end. It sits between the host byte interface and the result consumer.

---
 rtl/p2p_pkg.sv | 21 ++
 rtl/p2p_elem_mul.sv | 29 ++
 rtl/p2p_mult_ctrl.sv | 154 +++++++++++++++
 tb/tb_p2p_mult_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/p2p_pkg.sv
// Shared types and constants for the point-to-point matrix multiplier sequencer.
package p2p_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int N_ELEM_DEF = 8;
  localparam int IDX_W      = $clog2(N_ELEM_DEF);
  localparam int LAST_IDX   = N_ELEM_DEF - 1;

  // Index width for an arbitrary element count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p2p_elem_mul.sv
// Combinational unsigned element multiply with truncating or saturating
// reduction of the double-width product back to DATA_W bits.
module p2p_elem_mul #(
  parameter int DATA_W = 8,
  parameter int SAT    = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);

  logic [2*DATA_W-1:0] prod_s;

  function automatic logic [DATA_W-1:0] reduce_fn(input logic [2*DATA_W-1:0] p,
                                                   input logic sat_en);
    if (sat_en && (|p[2*DATA_W-1:DATA_W])) begin
      return {DATA_W{1'b1}};
    end else begin
      return p[DATA_W-1:0];
    end
  endfunction

  // Full-width product, then reduce according to the SAT mode.
  always_comb begin
    prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    res    = reduce_fn(prod_s, (SAT != 0));
  end

endmodule

// File: rtl/p2p_mult_ctrl.sv
// Sequencer: loads A then B over one byte stream, then streams A[i]*B[i]
// through a single shared multiplier under a valid/ready handshake.
module p2p_mult_ctrl
  import p2p_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 8,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IW = idx_width(N_ELEM);
  localparam logic [IW-1:0] LAST_C = IW'(N_ELEM - 1);
  localparam logic [IW-1:0] ZERO_C = IW'(1'b0);
  localparam logic [IW-1:0] ONE_C  = IW'(1'b1);

  state_t            state_r, state_nxt_s;
  logic [IW-1:0]     idx_r, idx_nxt_s, sel_s;
  logic [DATA_W-1:0] a_buf_r [N_ELEM];
  logic [DATA_W-1:0] b_buf_r [N_ELEM];
  logic [DATA_W-1:0] cout_r, mul_res_s;
  logic              out_valid_r, in_ready_r, busy_r, done_r;
  logic              out_valid_nxt_s, in_ready_nxt_s, busy_nxt_s, done_nxt_s;
  logic              cout_load_s, last_s, beat_s, accept_s;

  assign last_s   = (idx_r == LAST_C);
  assign beat_s   = in_valid && ((state_r == LOAD_A) || (state_r == LOAD_B));
  assign accept_s = out_valid_r && out_ready;

  p2p_elem_mul #(.DATA_W(DATA_W), .SAT(SAT)) u_mul (
    .a   (a_buf_r[sel_s]),
    .b   (b_buf_r[sel_s]),
    .res (mul_res_s)
  );

  // State and element index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state and index sequencing.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = LOAD_A;
          idx_nxt_s   = ZERO_C;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_A, LOAD_B: begin
        if (beat_s && last_s) begin
          state_nxt_s = (state_r == LOAD_A) ? LOAD_B : MULT;
          idx_nxt_s   = ZERO_C;
        end else if (beat_s) begin
          idx_nxt_s = idx_r + ONE_C;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      MULT: begin
        if (accept_s && last_s) begin
          state_nxt_s = DONE;
          idx_nxt_s   = ZERO_C;
        end else if (accept_s) begin
          idx_nxt_s = idx_r + ONE_C;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = ZERO_C;
      end
    endcase
  end

  // Output decode; flags are derived from the next state so they register cleanly.
  always_comb begin
    in_ready_nxt_s  = (state_nxt_s == LOAD_A) || (state_nxt_s == LOAD_B);
    busy_nxt_s      = (state_nxt_s != IDLE);
    done_nxt_s      = (state_nxt_s == DONE);
    out_valid_nxt_s = (state_nxt_s == MULT);
    cout_load_s     = ((state_r == LOAD_B) && beat_s && last_s) ||
                      ((state_r == MULT) && accept_s && !last_s);
    // Element 0 is fetched while finishing LOAD_B; in MULT look one ahead.
    if ((state_r == MULT) && !last_s) begin
      sel_s = idx_r + ONE_C;
    end else begin
      sel_s = ZERO_C;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cout_r      <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cout_r      <= cout_load_s ? mul_res_s : cout_r;
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Operand buffers; not cleared between runs since each run overwrites them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ELEM; i++) begin
        a_buf_r[i] <= {DATA_W{1'b0}};
        b_buf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (beat_s && (state_r == LOAD_A)) begin
      a_buf_r[idx_r] <= a_in;
    end else if (beat_s && (state_r == LOAD_B)) begin
      b_buf_r[idx_r] <= a_in;
    end else begin
      a_buf_r <= a_buf_r;
    end
  end

  assign cout      = cout_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_p2p_mult_ctrl.sv
// Self-checking bench: SAT=0 and SAT=1 instances share one stimulus stream and
// are compared against a product model computed with plain integer arithmetic.
module tb_p2p_mult_ctrl;

  localparam int DW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [DW-1:0] a_in;
  logic          ir0, ov0, bz0, dn0, ir1, ov1, bz1, dn1;
  logic [DW-1:0] c0, c1;

  int total = 0;
  int bad   = 0;
  int a_op [N];
  int b_op [N];

  always #5 clk = ~clk;

  p2p_mult_ctrl #(.DATA_W(DW), .N_ELEM(N), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .in_valid(in_valid),
    .in_ready(ir0), .cout(c0), .out_valid(ov0), .out_ready(out_ready),
    .busy(bz0), .done(dn0));

  p2p_mult_ctrl #(.DATA_W(DW), .N_ELEM(N), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .in_valid(in_valid),
    .in_ready(ir1), .cout(c1), .out_valid(ov1), .out_ready(out_ready),
    .busy(bz1), .done(dn1));

  function automatic logic [31:0] model(input int a, input int b, input int sat);
    int p, lim;
    p   = a * b;
    lim = (1 << DW) - 1;
    if (sat != 0) return (p > lim) ? lim : p;
    return p % (lim + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input bit ir, input bit ov, input bit dn, input bit bz);
    check({tag, "/in_ready0"}, ir0, ir);  check({tag, "/in_ready1"}, ir1, ir);
    check({tag, "/out_valid0"}, ov0, ov); check({tag, "/out_valid1"}, ov1, ov);
    check({tag, "/done0"}, dn0, dn);      check({tag, "/done1"}, dn1, dn);
    check({tag, "/busy0"}, bz0, bz);      check({tag, "/busy1"}, bz1, bz);
  endtask

  // rdy_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  task automatic run(input int gap_at, input bit stray_start, input int rdy_mode, input int rst_after);
    int  k, guard;
    bit  r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_ctl("load_entry", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * N; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check_ctl("gap", 1'b1, 1'b0, 1'b0, 1'b1);
        end
      end
      in_valid = 1'b1;
      a_in     = DW'((i < N) ? a_op[i] : b_op[i - N]);
      start    = stray_start && (i == N + 2);
      @(posedge clk); #1;
      if (i < 2 * N - 1) check_ctl("loading", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    k = 0;
    guard = 0;
    while (k < N && guard < 200) begin
      check_ctl("mult", 1'b0, 1'b1, 1'b0, 1'b1);
      check("cout_sat0", c0, model(a_op[k], b_op[k], 0));
      check("cout_sat1", c1, model(a_op[k], b_op[k], 1));
      if (rst_after >= 0 && k == rst_after) begin
        rst = 1'b0;
        #1;
        check_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_cout0", c0, 32'd0);
        check("rst_cout1", c1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_ctl("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      case (rdy_mode)
        1:       r = (guard % 4 == 0) || (guard % 4 == 3);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      out_ready = r;
      @(posedge clk); #1;
      guard++;
      if (r) k++;
    end
    check("mult_within_budget", {31'd0, guard < 200}, 32'd1);
    check_ctl("done", 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_ctl("idle_after", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_basic();
    int av [N] = '{12, 13, 112, 143, 12, 1, 11, 17};
    int bv [N] = '{13, 18, 10, 15, 16, 17, 33, 23};
    for (int i = 0; i < N; i++) begin
      a_op[i] = av[i];
      b_op[i] = bv[i];
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_cout0", c0, 32'd0);
    check("reset_cout1", c1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    set_basic();
    run(-1, 1'b0, 0, -1);

    run(-1, 1'b0, 1, -1);

    in_valid = 1'b1;
    a_in = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
      check_ctl("idle_stray", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    run(3, 1'b1, 0, -1);

    run(-1, 1'b0, 0, 3);
    run(-1, 1'b0, 0, -1);

    for (int i = 0; i < N; i++) begin
      a_op[i] = 255;
      b_op[i] = 1;
    end
    run(-1, 1'b0, 0, -1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        a_op[i] = int'($urandom_range(0, 255));
        b_op[i] = int'($urandom_range(0, 255));
      end
      run(-1, 1'b0, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
